// File: rtl/serial_word_pkg.sv
// Shared types and constants for the serial word transmit/receive datapath.
package serial_word_pkg;

    localparam int SERIAL_WORD_WIDTH_DEF = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } rx_state_t;

endpackage

// File: rtl/serial_bit_counter.sv
// Frame bit counter: loads 1 on frame start, counts accepted bits, and flags
// the increment that brings the count to WIDTH.
module serial_bit_counter
    import serial_word_pkg::*;
#(
    parameter int WIDTH = SERIAL_WORD_WIDTH_DEF,
    localparam int CW   = $clog2(WIDTH + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic inc_i,
    output logic done_o
);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = CW'(1);
        end else if (inc_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Terminal count is reached on the edge that takes the count to WIDTH.
    assign done_o = inc_i & ~clr_i & (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/serial_word_receiver.sv
// MSB-first serial-to-parallel word receiver with valid/ready output and sticky
// overrun. Define SERIAL_WORD_RECEIVER_PARITY_EN to add a trailing even-parity bit.
module serial_word_receiver
    import serial_word_pkg::*;
#(
    parameter int WIDTH = SERIAL_WORD_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sin,
    input  logic             sin_en,
    input  logic             start,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    input  logic             ready,
    output logic             overrun,
    output logic             parity_err
);

    rx_state_t        state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic             commit;
    logic [WIDTH-1:0] word;
    logic             cnt_clr, cnt_inc, cnt_done;
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
    logic             perr_q, perr_d;
    logic             word_perr;
`endif

    assign cnt_clr = sin_en & start;
    assign cnt_inc = sin_en & ~start & (state_q == SHIFT);

    serial_bit_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (cnt_clr),
        .inc_i  (cnt_inc),
        .done_o (cnt_done)
    );

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        commit    = 1'b0;
        word      = shreg_q;
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
        perr_d    = perr_q;
        word_perr = 1'b0;
`endif

        if (valid_q && ready) begin
            valid_d = 1'b0;
        end

        if (sin_en) begin
            if (start) begin
                // A start always wins: any partial frame is silently dropped.
                shreg_d    = '0;
                shreg_d[0] = sin;
                state_d    = SHIFT;
            end else begin
                case (state_q)
                    SHIFT: begin
                        shreg_d = {shreg_q[WIDTH-2:0], sin};
                        if (cnt_done) begin
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = IDLE;
                            commit  = 1'b1;
                            word    = shreg_d;
`endif
                        end
                    end
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
                    PARITY: begin
                        state_d   = IDLE;
                        commit    = 1'b1;
                        word_perr = ^{shreg_q, sin};
                    end
`endif
                    default: ;
                endcase
            end
        end

        if (commit) begin
            if (!valid_q || ready) begin
                data_d  = word;
                valid_d = 1'b1;
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
                perr_d  = word_perr;
`endif
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
            perr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
            perr_q    <= perr_d;
`endif
        end
    end

    assign data_out = data_q;
    assign valid    = valid_q;
    assign overrun  = overrun_q;
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_word_receiver.sv
// Directed and randomized bench for serial_word_receiver against a frame-level
// reference model; honours SERIAL_WORD_RECEIVER_PARITY_EN.
module tb_serial_word_receiver;

    localparam int W = 6;
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif
    localparam int FRAME = W + (PEN ? 1 : 0);

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         sin = 1'b0, sin_en = 1'b0, start = 1'b0, ready = 1'b0;
    logic [W-1:0] data_out;
    logic         valid, overrun, parity_err;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: frame progress and expected outputs.
    bit           m_in;
    int           m_bits;
    logic [W-1:0] m_word;
    logic [W-1:0] m_data;
    logic         m_valid, m_ovr, m_perr;

    serial_word_receiver #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .sin        (sin),
        .sin_en     (sin_en),
        .start      (start),
        .data_out   (data_out),
        .valid      (valid),
        .ready      (ready),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".data_out"},   32'(data_out),   32'(m_data));
        chk({tag, ".valid"},      32'(valid),      32'(m_valid));
        chk({tag, ".overrun"},    32'(overrun),    32'(m_ovr));
        chk({tag, ".parity_err"}, 32'(parity_err), 32'(m_perr));
    endtask

    task automatic model_reset();
        m_in = 0; m_bits = 0; m_word = '0;
        m_data = '0; m_valid = 0; m_ovr = 0; m_perr = 0;
    endtask

    task automatic model_step(input bit st, input bit s, input bit en, input bit rdy);
        bit commit = 0;
        bit pbit = 0;
        bit nv = m_valid && !rdy;
        if (en) begin
            if (st) begin
                m_in = 1; m_bits = 1; m_word = W'(s);
            end else if (m_in) begin
                m_bits++;
                if (m_bits <= W) m_word = (m_word << 1) | W'(s);
                else pbit = s;
                if (m_bits == FRAME) begin
                    m_in = 0;
                    commit = 1;
                end
            end
        end
        if (commit) begin
            if (!m_valid || rdy) begin
                m_data = m_word;
                nv = 1;
                m_perr = PEN ? ((^m_word) ^ pbit) : 1'b0;
            end else begin
                m_ovr = 1;
            end
        end
        m_valid = nv;
    endtask

    task automatic cycle(input bit st, input bit s, input bit en, input bit rdy);
        start = st; sin = s; sin_en = en; ready = rdy;
        model_step(st, s, en, rdy);
        @(posedge clk); #1;
        check_all("cyc");
    endtask

    task automatic do_reset();
        start = 0; sin = 0; sin_en = 0; ready = 0;
        reset = 1;
        #1;
        model_reset();
        check_all("reset_async");
        @(posedge clk); #1;
        reset = 0;
        check_all("reset_rel");
    endtask

    task automatic send_word(input logic [W-1:0] w, input int gap, input bit rdy, input bit pbit);
        for (int i = W - 1; i >= 0; i--) begin
            cycle(i == W - 1, w[i], 1'b1, rdy);
            for (int g = 0; g < gap; g++) cycle(1'b0, 1'b0, 1'b0, rdy);
        end
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
        cycle(1'b0, pbit, 1'b1, rdy);
`else
        if (pbit) begin end
`endif
    endtask

    initial begin
        logic [W-1:0] w;
        model_reset();
        do_reset();

        // Plain word, then consume.
        send_word(6'h2D, 0, 1'b0, 1'b0);
        chk("t1_valid", 32'(valid), 32'd1);
        chk("t1_data", 32'(data_out), 32'h2D);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t1_consumed", 32'(valid), 32'd0);

        // Same word with sin_en every third cycle.
        send_word(6'h2D, 2, 1'b0, 1'b0);
        chk("t2_data", 32'(data_out), 32'h2D);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);

        // Overrun: second word lost while first is unconsumed.
        send_word(6'h3F, 0, 1'b0, 1'b0);
        send_word(6'h01, 0, 1'b0, 1'b0);
        chk("t3_data", 32'(data_out), 32'h3F);
        chk("t3_ovr", 32'(overrun), 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t3_valid", 32'(valid), 32'd0);
        chk("t3_ovr_sticky", 32'(overrun), 32'd1);

        // Restart mid-frame.
        do_reset();
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        send_word(6'h15, 0, 1'b0, 1'b0);
        chk("t4_data", 32'(data_out), 32'h15);
        chk("t4_ovr", 32'(overrun), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);

        // Reset mid-frame, then a full word.
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        do_reset();
        send_word(6'h2A, 0, 1'b0, 1'b0);
        chk("t5_data", 32'(data_out), 32'h2A);

        // Back-to-back words with ready held high.
        send_word(6'h12, 0, 1'b1, 1'b0);
        send_word(6'h33, 0, 1'b1, 1'b1);
        chk("b2b_data", 32'(data_out), 32'h33);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);

`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
        send_word(6'h2D, 0, 1'b0, 1'b0);
        chk("t6_perr0", 32'(parity_err), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        send_word(6'h2D, 0, 1'b0, 1'b1);
        chk("t6_perr1", 32'(parity_err), 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
`endif

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                w = W'($urandom);
                cycle($urandom_range(0, 11) == 0, w[0], $urandom_range(0, 2) != 0,
                      $urandom_range(0, 1) == 1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
